intc_prio_seq: RTL and testbench
================================

INTC_PRIO_SEQ -- requirements
Module: intc_prio_seq

Interface
REQ-001: Parameter NBUS, default 3, sets the number of request buses; legal range 1..8.
REQ-002: Parameter NCH, default 9, sets the channels per bus; legal range 2..32.
REQ-003: Parameter EDGE, default 0, selects pending capture: 0 = level, 1 = rising edge.
REQ-004: Derived width CW = ceil(log2(NCH)) SHALL size CHAN.
REQ-005: CK, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-006: RST, input, 1 bit, is the reset; it is synchronous and active-high.
REQ-007: REQ, input, NBUS*NCH bits, carries the requests; bit b*NCH+c is bus b, channel c.
REQ-008: EN, input, NCH bits, is the per-channel enable, applied identically to every bus.
REQ-009: ACK, input, 1 bit, is the acknowledge from the servicing agent (4-phase handshake).
REQ-010: IRQ, output, 1 bit, is the interrupt request; the vector is valid while it is high.
REQ-011: BUS, output, NBUS bits, is the one-hot bus of the granted request.
REQ-012: CHAN, output, CW bits, is the binary channel index of the granted request.
REQ-013: PEND, output, NBUS*NCH bits, is the registered pending vector.
REQ-014: OVF, output, 1 bit, is a sticky overrun flag.

Function
REQ-015: Level mode: PEND SHALL load REQ on every edge, and ACK SHALL NOT modify PEND.
REQ-016: Edge mode: a PEND bit SHALL set when the REQ bit is 1 now and was 0 in the previous cycle.
REQ-017: Edge mode: the PEND bit of the granted request SHALL clear on the edge where ACK is sampled high in ASSERT.
REQ-018: Edge mode, new edge and clear on the same bit in the same cycle: set SHALL win, and the bit SHALL remain 1.
REQ-019: Eligibility: eligible[b*NCH+c] = PEND[b*NCH+c] AND EN[c].
REQ-020: Priority: a lower bus index beats any higher bus index; within a bus, a lower channel index wins.
REQ-021: The FSM SHALL have exactly three states: IDLE, ASSERT, RELEASE.
REQ-022: IDLE -> ASSERT when any bit is eligible; the winner's bus and channel are latched on the same edge.
REQ-023: ASSERT: IRQ = 1, and BUS/CHAN SHALL hold the latched vector, stable until exit.
REQ-024: ASSERT -> RELEASE on the edge where ACK = 1.
REQ-025: RELEASE: IRQ = 0; the FSM SHALL wait for ACK = 0.
REQ-026: RELEASE -> IDLE on the edge where ACK = 0.
REQ-027: Whenever the state is not ASSERT, BUS SHALL be 0 and CHAN SHALL be 0.
REQ-028: There SHALL be no preemption: a higher-priority request during ASSERT or RELEASE SHALL NOT alter the vector; it is granted on a later IDLE pass.
REQ-029: In ASSERT, withdrawal of the granted request (REQ drop or EN drop) SHALL NOT deassert IRQ; the vector is held until ACK.
REQ-030: ACK in IDLE SHALL be ignored.
REQ-031: Latency: REQ high at edge t (with EN high and the FSM idle) SHALL give PEND at t and IRQ = 1 after edge t+1.
REQ-032: Minimum service cycle is 4 edges (IDLE, ASSERT, RELEASE, IDLE); back-to-back grants SHALL need no extra idle cycle beyond IDLE.
REQ-033: Edge mode: OVF SHALL set when a rising edge arrives on a bit that is already pending and is not being cleared that cycle.
REQ-034: OVF SHALL clear only on reset; in level mode OVF SHALL stay 0.

Reset
REQ-035: With RST = 1 at an edge, the block SHALL force: state IDLE; IRQ = 0; BUS = 0; CHAN = 0; PEND = 0; OVF = 0.
REQ-036: During reset, the previous-REQ register SHALL load the current REQ, so a request held high through reset creates no edge.
REQ-037: RST SHALL take priority over ACK and REQ in the same cycle.
REQ-038: RST asserted mid-handshake (ASSERT or RELEASE) SHALL abort to IDLE; a held ACK after reset SHALL be ignored.

Verification
REQ-039: Defaults, EDGE = 0, EN = all 1: REQ bits 13 and 20 set → after 2 edges IRQ = 1, BUS = 3'b010, CHAN = 4; after ACK 1 then 0, FSM returns to IDLE.
REQ-040: Defaults, EDGE = 1: pulse REQ bit 0 and bit 26 → grant bus 0 / channel 0, then after handshake bus 2 / channel 8; PEND = 0 at end.
REQ-041: EDGE = 1: pulse bit 5 twice before ACK → OVF = 1 and remains 1 until RST.
REQ-042: EDGE = 1: second edge on the granted bit in the ACK cycle → PEND bit stays 1; the same vector is regranted.
REQ-043: EN[4] = 0 with only bit 4 requested → IRQ stays 0; raising EN[4] → IRQ = 1 two edges later.
REQ-044: RST pulsed during ASSERT while REQ bit 9 is held high (EDGE = 1) → all outputs 0, and no regrant after reset.

Source files
------------

// File: rtl/intc_prio_seq.sv
// Priority interrupt sequencer: captures requests from NBUS x NCH sources, grants the
// highest-priority eligible one and runs a 4-phase IRQ/ACK handshake per grant.
module intc_prio_seq #(
    parameter int unsigned NBUS = 3,
    parameter int unsigned NCH  = 9,
    parameter int unsigned EDGE = 0,
    localparam int unsigned CW  = $clog2(NCH)
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic [NBUS*NCH-1:0]  REQ,
    input  logic [NCH-1:0]       EN,
    input  logic                 ACK,
    output logic                 IRQ,
    output logic [NBUS-1:0]      BUS,
    output logic [CW-1:0]        CHAN,
    output logic [NBUS*NCH-1:0]  PEND,
    output logic                 OVF
);

    localparam int unsigned NB = NBUS * NCH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state;
    logic [NB-1:0]   req_prev;
    logic [NB-1:0]   eligible;
    logic [NB-1:0]   rise;
    logic [NB-1:0]   clr;
    logic [NB-1:0]   pend_next;
    logic            ovf_set;
    logic            any_elig;
    logic [NBUS-1:0] win_bus;
    logic [CW-1:0]   win_chan;

    // Eligibility and the clear mask for the currently granted vector
    always_comb begin
        eligible = '0;
        clr      = '0;
        for (int b = 0; b < int'(NBUS); b++) begin
            for (int c = 0; c < int'(NCH); c++) begin
                eligible[b*NCH+c] = PEND[b*NCH+c] & EN[c];
                clr[b*NCH+c]      = (state == ASSERT) && ACK && BUS[b] && (CHAN == CW'(c));
            end
        end
    end

    // Fixed priority: lowest bus first, then lowest channel within the bus
    always_comb begin
        any_elig = 1'b0;
        win_bus  = '0;
        win_chan = '0;
        for (int b = 0; b < int'(NBUS); b++) begin
            for (int c = 0; c < int'(NCH); c++) begin
                if (eligible[b*NCH+c] && !any_elig) begin
                    any_elig = 1'b1;
                    win_bus  = NBUS'(1) << b;
                    win_chan = CW'(c);
                end
            end
        end
    end

    // Pending update; in edge mode a new edge wins over a simultaneous clear
    always_comb begin
        rise      = REQ & ~req_prev;
        pend_next = REQ;
        ovf_set   = 1'b0;
        if (EDGE != 0) begin
            pend_next = (PEND & ~clr) | rise;
            ovf_set   = |(rise & PEND & ~clr);
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state    <= IDLE;
            IRQ      <= 1'b0;
            BUS      <= '0;
            CHAN     <= '0;
            PEND     <= '0;
            OVF      <= 1'b0;
            req_prev <= REQ;
        end else begin
            req_prev <= REQ;
            PEND     <= pend_next;
            if (ovf_set) begin
                OVF <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        state <= ASSERT;
                        IRQ   <= 1'b1;
                        BUS   <= win_bus;
                        CHAN  <= win_chan;
                    end
                end
                ASSERT: begin
                    if (ACK) begin
                        state <= RELEASE;
                        IRQ   <= 1'b0;
                        BUS   <= '0;
                        CHAN  <= '0;
                    end
                end
                RELEASE: begin
                    if (!ACK) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    IRQ   <= 1'b0;
                    BUS   <= '0;
                    CHAN  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intc_prio_seq.sv
// Directed bench for intc_prio_seq: one level-mode and one edge-mode instance on shared inputs.
module tb_intc_prio_seq;

    localparam int unsigned NBUS = 3;
    localparam int unsigned NCH  = 9;
    localparam int unsigned NB   = NBUS * NCH;
    localparam int unsigned CW   = $clog2(NCH);

    logic           CK;
    logic           RST;
    logic [NB-1:0]  REQ;
    logic [NCH-1:0] EN;
    logic           ACK;

    logic            l_irq, e_irq;
    logic [NBUS-1:0] l_bus, e_bus;
    logic [CW-1:0]   l_chan, e_chan;
    logic [NB-1:0]   l_pend, e_pend;
    logic            l_ovf, e_ovf;

    int n_cmp = 0;
    int n_err = 0;

    intc_prio_seq #(.NBUS(NBUS), .NCH(NCH), .EDGE(0)) u_lvl (
        .CK(CK), .RST(RST), .REQ(REQ), .EN(EN), .ACK(ACK),
        .IRQ(l_irq), .BUS(l_bus), .CHAN(l_chan), .PEND(l_pend), .OVF(l_ovf)
    );

    intc_prio_seq #(.NBUS(NBUS), .NCH(NCH), .EDGE(1)) u_edge (
        .CK(CK), .RST(RST), .REQ(REQ), .EN(EN), .ACK(ACK),
        .IRQ(e_irq), .BUS(e_bus), .CHAN(e_chan), .PEND(e_pend), .OVF(e_ovf)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling
    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    function automatic logic [NB-1:0] bit_of(input int unsigned i);
        logic [NB-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        RST = 1'b1;
        REQ = '0;
        EN  = '1;
        ACK = 1'b0;
        tick();
        tick();
        // Reset state
        check("rst_l_irq",  64'(l_irq),  64'd0);
        check("rst_l_bus",  64'(l_bus),  64'd0);
        check("rst_l_chan", 64'(l_chan), 64'd0);
        check("rst_l_pend", 64'(l_pend), 64'd0);
        check("rst_e_irq",  64'(e_irq),  64'd0);
        check("rst_e_pend", 64'(e_pend), 64'd0);
        check("rst_e_ovf",  64'(e_ovf),  64'd0);
        RST = 1'b0;

        // Level mode: bits 13 (bus1 ch4) and 20 (bus2 ch2)
        REQ = bit_of(13) | bit_of(20);
        tick();
        check("lvl_pend_t",  64'(l_pend), 64'(bit_of(13) | bit_of(20)));
        check("lvl_irq_t",   64'(l_irq),  64'd0);
        tick();
        check("lvl_irq_t1",  64'(l_irq),  64'd1);
        check("lvl_bus_t1",  64'(l_bus),  64'(3'b010));
        check("lvl_chan_t1", 64'(l_chan), 64'd4);
        // Higher-priority arrival must not preempt
        REQ = REQ | bit_of(0);
        tick();
        check("nopre_irq",  64'(l_irq),  64'd1);
        check("nopre_bus",  64'(l_bus),  64'(3'b010));
        check("nopre_chan", 64'(l_chan), 64'd4);
        ACK = 1'b1;
        tick();
        check("rel_irq",  64'(l_irq),  64'd0);
        check("rel_bus",  64'(l_bus),  64'd0);
        check("rel_chan", 64'(l_chan), 64'd0);
        ACK = 1'b0;
        tick();
        check("idle_irq", 64'(l_irq), 64'd0);
        tick();
        check("b2b_irq",  64'(l_irq),  64'd1);
        check("b2b_bus",  64'(l_bus),  64'(3'b001));
        check("b2b_chan", 64'(l_chan), 64'd0);
        check("lvl_ovf",  64'(l_ovf),  64'd0);
        REQ = '0;
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tick();
        tick();
        check("lvl_done_irq", 64'(l_irq), 64'd0);

        // Level mode priority: bus0 ch8 beats bus1 ch0
        do_reset();
        REQ = bit_of(8) | bit_of(9);
        tick();
        tick();
        check("prio_bus",  64'(l_bus),  64'(3'b001));
        check("prio_chan", 64'(l_chan), 64'd8);
        REQ = '0;
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tick();

        // Edge mode: pulse bits 0 and 26
        do_reset();
        REQ = bit_of(0) | bit_of(26);
        tick();
        REQ = '0;
        check("e40_pend", 64'(e_pend), 64'(bit_of(0) | bit_of(26)));
        tick();
        check("e40_irq1",  64'(e_irq),  64'd1);
        check("e40_bus1",  64'(e_bus),  64'(3'b001));
        check("e40_chan1", 64'(e_chan), 64'd0);
        ACK = 1'b1;
        tick();
        check("e40_pend_clr", 64'(e_pend), 64'(bit_of(26)));
        ACK = 1'b0;
        tick();
        tick();
        check("e40_irq2",  64'(e_irq),  64'd1);
        check("e40_bus2",  64'(e_bus),  64'(3'b100));
        check("e40_chan2", 64'(e_chan), 64'd8);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tick();
        check("e40_pend_end", 64'(e_pend), 64'd0);
        check("e40_irq_end",  64'(e_irq),  64'd0);
        check("e40_ovf",      64'(e_ovf),  64'd0);

        // Edge mode overrun: second edge on bit 5 before ACK
        do_reset();
        REQ = bit_of(5);
        tick();
        REQ = '0;
        tick();
        check("ovf_chan", 64'(e_chan), 64'd5);
        REQ = bit_of(5);
        tick();
        REQ = '0;
        check("ovf_set", 64'(e_ovf), 64'd1);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tick();
        tick();
        tick();
        check("ovf_sticky", 64'(e_ovf), 64'd1);
        do_reset();
        check("ovf_rst", 64'(e_ovf), 64'd0);

        // Edge mode: new edge on the granted bit in the ACK cycle
        REQ = bit_of(5);
        tick();
        REQ = '0;
        tick();
        ACK = 1'b1;
        REQ = bit_of(5);
        tick();
        check("sw_pend", 64'(e_pend), 64'(bit_of(5)));
        check("sw_ovf",  64'(e_ovf),  64'd0);
        check("sw_irq",  64'(e_irq),  64'd0);
        ACK = 1'b0;
        REQ = '0;
        tick();
        tick();
        check("sw_regrant_bus",  64'(e_bus),  64'(3'b001));
        check("sw_regrant_chan", 64'(e_chan), 64'd5);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tick();

        // Channel enable masks bit 4 (level mode)
        do_reset();
        EN  = ~(NCH'(1) << 4);
        REQ = bit_of(4);
        tick();
        tick();
        tick();
        check("en_masked_irq", 64'(l_irq), 64'd0);
        check("en_pend",       64'(l_pend), 64'(bit_of(4)));
        EN = '1;
        tick();
        tick();
        check("en_irq",  64'(l_irq),  64'd1);
        check("en_chan", 64'(l_chan), 64'd4);
        REQ = '0;
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        tick();

        // Edge mode: reset during ASSERT with bit 9 held and ACK high
        do_reset();
        REQ = bit_of(9);
        tick();
        tick();
        check("ra_irq", 64'(e_irq), 64'd1);
        check("ra_bus", 64'(e_bus), 64'(3'b010));
        RST = 1'b1;
        ACK = 1'b1;
        tick();
        RST = 1'b0;
        check("ra_irq0",  64'(e_irq),  64'd0);
        check("ra_bus0",  64'(e_bus),  64'd0);
        check("ra_chan0", 64'(e_chan), 64'd0);
        check("ra_pend0", 64'(e_pend), 64'd0);
        tick();
        tick();
        ACK = 1'b0;
        tick();
        tick();
        check("ra_noregrant_irq",  64'(e_irq),  64'd0);
        check("ra_noregrant_pend", 64'(e_pend), 64'd0);
        check("ra_noregrant_bus",  64'(e_bus),  64'd0);
        REQ = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
